// File: rtl/password_tx_sequencer.sv
// password_tx_sequencer: sends an 8-character password as back-to-back 8N1 frames,
// then watches the target's unlock LED through a settle window and reports the result.
module password_tx_sequencer #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD = 115200,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] password,
  input  logic        led_g_n,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        unlocked
);
  localparam int BAUD_P = CLK_HZ / BAUD;
  localparam int BW = $clog2(BAUD_P) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BIT, STOP_BIT, SETTLE, DONE} state_t;
  state_t state;
  logic [BW-1:0] baud_cnt;
  logic [SW-1:0] settle_cnt;
  logic [2:0] bit_cnt, chr_cnt;
  logic [63:0] shreg;
  logic [1:0] led_sync;
  logic bit_end;
  assign bit_end = baud_cnt == BW'(BAUD_P - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      tx <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      unlocked <= 1'b0;
      baud_cnt <= '0;
      settle_cnt <= '0;
      bit_cnt <= '0;
      chr_cnt <= '0;
      shreg <= '0;
      led_sync <= 2'b11;
    end else begin
      led_sync <= {led_sync[0], led_g_n};
      done <= 1'b0;
      if (state != IDLE && !led_sync[1]) unlocked <= 1'b1;
      baud_cnt <= (state inside {START_BIT, DATA_BIT, STOP_BIT}) && !bit_end ? baud_cnt + 1'b1 : '0;
      case (state)
        IDLE: if (start) begin
          shreg <= password;
          unlocked <= 1'b0;
          busy <= 1'b1;
          tx <= 1'b0;
          chr_cnt <= '0;
          state <= START_BIT;
        end
        START_BIT: if (bit_end) begin
          tx <= shreg[0];
          bit_cnt <= '0;
          state <= DATA_BIT;
        end
        // shreg shifts once per data bit, so the next character's LSB lands in shreg[0]
        DATA_BIT: if (bit_end) begin
          shreg <= shreg >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          tx <= bit_cnt == 3'd7 ? 1'b1 : shreg[1];
          if (bit_cnt == 3'd7) state <= STOP_BIT;
        end
        STOP_BIT: if (bit_end) begin
          chr_cnt <= chr_cnt == 3'd7 ? 3'd0 : chr_cnt + 1'b1;
          tx <= chr_cnt == 3'd7;
          state <= chr_cnt == 3'd7 ? SETTLE : START_BIT;
          settle_cnt <= '0;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_password_tx_sequencer.sv
// tb_password_tx_sequencer: scoreboard bench; frame and done monitors pop expected
// characters and unlock results queued by the stimulus.
module tb_password_tx_sequencer;
  localparam int BP = 104;
  localparam int T_DONE = 80 * BP + 1000;
  logic clk = 0, reset, start, led_g_n, tx, busy, done, unlocked;
  logic [63:0] password;
  int total = 0, bad = 0;
  logic [7:0] exp_chars[$];
  bit exp_unl_q[$];

  password_tx_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .password(password), .led_g_n(led_g_n),
    .tx(tx), .busy(busy), .done(done), .unlocked(unlocked)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  // frame monitor: tx must hold each bit for exactly BP clocks
  int mcnt;
  bit in_fr, glitch, stop_bad;
  logic cur;
  logic [7:0] mb, me;
  initial forever begin
    @(negedge clk);
    if (reset) in_fr = 0;
    else if (!in_fr) begin
      if (tx === 1'b0) begin
        in_fr = 1; mcnt = 0; glitch = 0; stop_bad = 0; cur = 0;
      end
    end else begin
      mcnt++;
      if (mcnt % BP == 0) begin
        cur = tx;
        if (mcnt / BP >= 1 && mcnt / BP <= 8) mb[mcnt / BP - 1] = tx;
        if (mcnt / BP == 9 && tx !== 1'b1) stop_bad = 1;
      end else if (tx !== cur) glitch = 1;
      if (mcnt == 10 * BP - 1) begin
        in_fr = 0;
        total++;
        if (exp_chars.size() == 0) begin
          bad++;
          $display("FAIL frame_unexpected got=%0h want=none", mb);
        end else begin
          me = exp_chars.pop_front();
          if (glitch || stop_bad || mb !== me) begin
            bad++;
            $display("FAIL frame got=%0h (glitch=%0d stop_bad=%0d) want=%0h", mb, glitch, stop_bad, me);
          end
        end
      end
    end
  end

  bit de;
  initial forever begin
    @(negedge clk);
    if (!reset && done === 1'b1) begin
      total++;
      if (exp_unl_q.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected got=done want=no_done t=%0t", $time);
      end else begin
        de = exp_unl_q.pop_front();
        if (unlocked !== de) begin
          bad++;
          $display("FAIL done_unlocked got=%b want=%b", unlocked, de);
        end
      end
    end
  end

  task automatic attempt(input logic [63:0] pw, input int led_at, input bit spam, input bit hold, input bit exp_unl);
    int n;
    bit seen, busy_ok;
    start = 1;
    password = pw;
    for (int k = 0; k < 8; k++) exp_chars.push_back(pw[8*k +: 8]);
    exp_unl_q.push_back(exp_unl);
    @(posedge clk);
    @(negedge clk);
    check("accept_tx", tx, 0);
    check("accept_busy", busy, 1);
    check("accept_unl_clear", unlocked, 0);
    n = 0; seen = 0; busy_ok = 1;
    while (!seen && n < T_DONE + 80) begin
      start = spam || hold;
      if (spam) password = ~pw ^ {2{32'(n)}};
      led_g_n = !(led_at >= 0 && n >= led_at && n < led_at + 3);
      @(negedge clk);
      n++;
      if (done) seen = 1;
      else if (!busy) busy_ok = 0;
    end
    check("done_seen", seen, 1);
    check("done_time", (n >= T_DONE - 1 && n <= T_DONE + 1) ? T_DONE : n, T_DONE);
    check("busy_held", busy_ok, 1);
    start = hold;
    password = pw;
    led_g_n = 1;
    @(negedge clk);
    check("idle_gap_busy", busy, 0);
    check("idle_gap_done", done, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout want=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; start = 0; password = '0; led_g_n = 1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_unl", unlocked, 0);
    reset = 0;
    @(negedge clk);
    attempt(64'h3231656d6b636168, -1, 0, 0, 0);
    attempt(64'h0123456789abcdef, 5 * 10 * BP + 300, 0, 0, 1);
    check("unl_sticky0", unlocked, 1);
    repeat (5) @(negedge clk);
    check("unl_sticky1", unlocked, 1);
    attempt(64'h3231656d6b636168, -1, 1, 0, 0);
    start = 1;
    password = 64'hfedcba9876543210;
    for (int k = 0; k < 3; k++) exp_chars.push_back(password[8*k +: 8]);
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (4000) @(negedge clk);
    #2 reset = 1;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    exp_chars.delete();
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (1200) @(negedge clk);
    check("abort_idle_tx", tx, 1);
    check("abort_idle_busy", busy, 0);
    attempt(64'h5a5aa5a5c3c33c3c, -1, 0, 1, 0);
    attempt(64'h8000000000000001, -1, 0, 0, 0);
    repeat (20) @(negedge clk);
    check("chars_left", exp_chars.size(), 0);
    check("dones_left", exp_unl_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
